// File: rtl/sobel_window3x3_if.sv
// sobel_window3x3_if
// Groups the pixel-in and window-out handshakes of sobel_window3x3.
//   pix_in/in_valid/in_ready : raster-order pixel stream into the block
//   z1..z9                   : 3x3 window, row-major (z1 top-left, z5 centre, z9 bottom-right)
//   out_valid/out_ready      : window handshake
//   out_last                 : last window of the frame, qualified by out_valid
// master = pixel source / window sink; slave = the window generator.
interface sobel_window3x3_if;
  logic [7:0] pix_in;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] z1, z2, z3, z4, z5, z6, z7, z8, z9;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (
    output pix_in, in_valid, out_ready,
    input  in_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9, out_valid, out_last
  );

  modport slave (
    input  pix_in, in_valid, out_ready,
    output in_ready, z1, z2, z3, z4, z5, z6, z7, z8, z9, out_valid, out_last
  );
endinterface

// File: rtl/sobel_window3x3.sv
// sobel_window3x3
// Turns a raster-order 8-bit pixel stream into 3x3 windows for a Sobel stage. Two line buffers
// hold the previous two rows; a 3x3 shift register forms the window. Only interior windows
// (accepted pixel at row>=2, col>=2) are emitted, so no border padding is ever produced.
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   io_win : slave side of sobel_window3x3_if (pixel in, window out, handshakes, out_last)
module sobel_window3x3 #(
  parameter int unsigned IMG_W = 64,
  parameter int unsigned IMG_H = 64
) (
  input logic               clk,
  input logic               rst,
  sobel_window3x3_if.slave  io_win
);
  localparam int unsigned ColW = $clog2(IMG_W);
  localparam int unsigned RowW = $clog2(IMG_H);
  localparam logic [ColW-1:0] ColMax = ColW'(IMG_W - 1);
  localparam logic [RowW-1:0] RowMax = RowW'(IMG_H - 1);
  localparam logic [ColW-1:0] ColTwo = ColW'(2);
  localparam logic [RowW-1:0] RowTwo = RowW'(2);

  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic [7:0]      r_lb1 [IMG_W];  // row r-1
  logic [7:0]      r_lb2 [IMG_W];  // row r-2
  logic [7:0]      r_win [9];      // row-major, index 0 = z1
  logic            r_out_valid;
  logic            r_out_last;

  logic w_accept;
  logic w_col_wrap;
  logic w_row_wrap;
  logic w_qualify;

  // Single output stage: a new window may load in the same cycle the old one is consumed.
  assign io_win.in_ready = !r_out_valid || io_win.out_ready;
  assign w_accept        = io_win.in_valid && io_win.in_ready;
  assign w_col_wrap      = (r_col == ColMax);
  assign w_row_wrap      = (r_row == RowMax);
  // Column gating also discards window columns left over from the previous row.
  assign w_qualify       = (r_row >= RowTwo) && (r_col >= ColTwo);

  // Line buffers are deliberately not reset; the qualify gate keeps stale rows off the outputs.
  always_ff @(posedge clk) begin
    if (!rst && w_accept) begin
      r_lb2[r_col] <= r_lb1[r_col];
      r_lb1[r_col] <= io_win.pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col       <= '0;
      r_row       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      for (int i = 0; i < 9; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_accept) begin
      r_col <= w_col_wrap ? '0 : r_col + 1'b1;
      if (w_col_wrap) begin
        r_row <= w_row_wrap ? '0 : r_row + 1'b1;
      end
      // Shift left; new right column is (row r-2, row r-1, incoming pixel) at this column.
      r_win[0] <= r_win[1];
      r_win[1] <= r_win[2];
      r_win[2] <= r_lb2[r_col];
      r_win[3] <= r_win[4];
      r_win[4] <= r_win[5];
      r_win[5] <= r_lb1[r_col];
      r_win[6] <= r_win[7];
      r_win[7] <= r_win[8];
      r_win[8] <= io_win.pix_in;
      r_out_valid <= w_qualify;
      r_out_last  <= w_qualify && w_col_wrap && w_row_wrap;
    end else if (io_win.out_ready) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

  assign io_win.out_valid = r_out_valid;
  assign io_win.out_last  = r_out_last;
  assign io_win.z1 = r_win[0];
  assign io_win.z2 = r_win[1];
  assign io_win.z3 = r_win[2];
  assign io_win.z4 = r_win[3];
  assign io_win.z5 = r_win[4];
  assign io_win.z6 = r_win[5];
  assign io_win.z7 = r_win[6];
  assign io_win.z8 = r_win[7];
  assign io_win.z9 = r_win[8];
endmodule

// File: tb/tb_sobel_window3x3.sv
// tb_sobel_window3x3
// Self-checking bench for sobel_window3x3. Instances: A 4x4 (directed), B 5x3, C 7x5, D 3x3
// (random handshakes checked against a direct 2-D window model).
// Windows are packed as {out_last, z1..z9} (73 bits).
module tb_sobel_window3x3;
  typedef logic [7:0]  pix_q [$];
  typedef logic [72:0] win_q [$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  sobel_window3x3_if ifa ();
  sobel_window3x3_if ifb ();
  sobel_window3x3_if ifc ();
  sobel_window3x3_if ifd ();

  sobel_window3x3 #(.IMG_W(4), .IMG_H(4)) u_dut_a (.clk(clk), .rst(rst), .io_win(ifa.slave));
  sobel_window3x3 #(.IMG_W(5), .IMG_H(3)) u_dut_b (.clk(clk), .rst(rst), .io_win(ifb.slave));
  sobel_window3x3 #(.IMG_W(7), .IMG_H(5)) u_dut_c (.clk(clk), .rst(rst), .io_win(ifc.slave));
  sobel_window3x3 #(.IMG_W(3), .IMG_H(3)) u_dut_d (.clk(clk), .rst(rst), .io_win(ifd.slave));

  logic [72:0] w_a, w_b, w_c, w_d;
  assign w_a = {ifa.out_last, ifa.z1, ifa.z2, ifa.z3, ifa.z4, ifa.z5, ifa.z6, ifa.z7, ifa.z8, ifa.z9};
  assign w_b = {ifb.out_last, ifb.z1, ifb.z2, ifb.z3, ifb.z4, ifb.z5, ifb.z6, ifb.z7, ifb.z8, ifb.z9};
  assign w_c = {ifc.out_last, ifc.z1, ifc.z2, ifc.z3, ifc.z4, ifc.z5, ifc.z6, ifc.z7, ifc.z8, ifc.z9};
  assign w_d = {ifd.out_last, ifd.z1, ifd.z2, ifd.z3, ifd.z4, ifd.z5, ifd.z6, ifd.z7, ifd.z8, ifd.z9};

  pix_q pix_a, pix_b, pix_c, pix_d;
  win_q obs_a, obs_b, obs_c, obs_d;
  win_q exp44, e;

  // Window transfers happen at the next posedge; handshakes are stable from posedge+1 onward.
  always @(negedge clk) begin
    if (ifa.out_valid && ifa.out_ready) obs_a.push_back(w_a);
    if (ifb.out_valid && ifb.out_ready) obs_b.push_back(w_b);
    if (ifc.out_valid && ifc.out_ready) obs_c.push_back(w_c);
    if (ifd.out_valid && ifd.out_ready) obs_d.push_back(w_d);
  end

  task automatic check_eq(input string tag, input logic [72:0] act, input logic [72:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [72:0] mkw(input logic l, input logic [71:0] v);
    return {l, v};
  endfunction

  function automatic int count_last(input win_q q);
    int n = 0;
    foreach (q[i]) if (q[i][72]) n++;
    return n;
  endfunction

  // Reference: every interior window of every whole frame, built by direct 2-D indexing.
  task automatic build_exp(input int w, input int h, input pix_q p, output win_q q);
    int frames;
    logic [71:0] v;
    frames = p.size() / (w * h);
    q = {};
    for (int f = 0; f < frames; f++)
      for (int r = 2; r < h; r++)
        for (int c = 2; c < w; c++) begin
          v = '0;
          for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++)
              v = {v[63:0], p[f * w * h + (r - 2 + dr) * w + (c - 2 + dc)]};
          q.push_back({(r == h - 1) && (c == w - 1), v});
        end
  endtask

  task automatic cmp_q(input string tag, input win_q obs, input win_q exq);
    check_eq({tag, "_count"}, 73'(obs.size()), 73'(exq.size()));
    for (int i = 0; i < exq.size() && i < obs.size(); i++)
      check_eq($sformatf("%s_win%0d", tag, i), obs[i], exq[i]);
  endtask

  // Streams pix_a[0..n-1] into DUT A with in_valid held high. If stall_n > 0, out_ready is
  // dropped for stall_n cycles from the moment the first window appears.
  task automatic run_a(input int n, input int stall_n);
    int idx = 0;
    int cyc = 0;
    int stalled = 0;
    bit seen = 1'b0;
    bit lat_pend = 1'b0;
    logic [72:0] held = '0;
    while (idx < n && cyc < 500) begin
      @(posedge clk); #1;
      cyc++;
      if (stall_n > 0 && !seen && ifa.out_valid) begin
        seen = 1'b1;
        stalled = stall_n;
        held = w_a;
      end
      ifa.in_valid  = 1'b1;
      ifa.pix_in    = pix_a[idx];
      ifa.out_ready = (stalled == 0);
      @(negedge clk);
      if (lat_pend) begin
        check_eq("latency_valid", 73'(ifa.out_valid), 73'(1));
        check_eq("latency_z9", 73'(ifa.z9), 73'(pix_a[10]));
        lat_pend = 1'b0;
      end
      if (stalled > 0) begin
        check_eq("stall_in_ready", 73'(ifa.in_ready), 73'(0));
        check_eq("stall_hold", w_a, held);
        stalled--;
      end
      if (ifa.in_valid && ifa.in_ready) begin
        if (idx == 10) lat_pend = 1'b1;
        idx++;
      end
    end
    check_eq("run_a_timeout", 73'(cyc < 500), 73'(1));
    @(posedge clk); #1;
    ifa.in_valid  = 1'b0;
    ifa.out_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic run_rand();
    int ib = 0;
    int ic = 0;
    int id = 0;
    int cyc = 0;
    while ((ib < pix_b.size() || ic < pix_c.size() || id < pix_d.size()) && cyc < 4000) begin
      @(posedge clk); #1;
      cyc++;
      ifb.in_valid  = (ib < pix_b.size()) && ($urandom_range(1, 0) == 1);
      ifb.pix_in    = (ib < pix_b.size()) ? pix_b[ib] : 8'h00;
      ifb.out_ready = 1'b1;
      ifc.in_valid  = (ic < pix_c.size()) && ($urandom_range(1, 0) == 1);
      ifc.pix_in    = (ic < pix_c.size()) ? pix_c[ic] : 8'h00;
      ifc.out_ready = ($urandom_range(3, 0) != 0);
      ifd.in_valid  = (id < pix_d.size()) && ($urandom_range(3, 0) != 0);
      ifd.pix_in    = (id < pix_d.size()) ? pix_d[id] : 8'h00;
      ifd.out_ready = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (ifb.in_valid && ifb.in_ready) ib++;
      if (ifc.in_valid && ifc.in_ready) ic++;
      if (ifd.in_valid && ifd.in_ready) id++;
    end
    check_eq("rand_timeout", 73'(cyc < 4000), 73'(1));
    @(posedge clk); #1;
    ifb.in_valid = 1'b0; ifc.in_valid = 1'b0; ifd.in_valid = 1'b0;
    ifb.out_ready = 1'b1; ifc.out_ready = 1'b1; ifd.out_ready = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ifa.in_valid = 1'b0; ifa.pix_in = 8'h00; ifa.out_ready = 1'b1;
    ifb.in_valid = 1'b0; ifb.pix_in = 8'h00; ifb.out_ready = 1'b1;
    ifc.in_valid = 1'b0; ifc.pix_in = 8'h00; ifc.out_ready = 1'b1;
    ifd.in_valid = 1'b0; ifd.pix_in = 8'h00; ifd.out_ready = 1'b1;

    // Hand-computed windows of a 4x4 frame holding 0..15.
    exp44 = {mkw(1'b0, 72'h00_01_02_04_05_06_08_09_0A),
             mkw(1'b0, 72'h01_02_03_05_06_07_09_0A_0B),
             mkw(1'b0, 72'h04_05_06_08_09_0A_0C_0D_0E),
             mkw(1'b1, 72'h05_06_07_09_0A_0B_0D_0E_0F)};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", 73'(ifa.out_valid), 73'(0));
    check_eq("rst_window_and_last", w_a, 73'(0));
    check_eq("rst_in_ready", 73'(ifa.in_ready), 73'(1));

    // Single 4x4 frame, continuous flow.
    pix_a = {};
    for (int i = 0; i < 16; i++) pix_a.push_back(8'(i));
    obs_a = {};
    run_a(16, 0);
    cmp_q("frame44", obs_a, exp44);

    // Same frame with a 5-cycle downstream stall on the first window.
    obs_a = {};
    run_a(16, 5);
    cmp_q("stall44", obs_a, exp44);

    // Two back-to-back frames.
    for (int i = 0; i < 16; i++) pix_a.push_back(8'(100 + i));
    obs_a = {};
    run_a(32, 0);
    build_exp(4, 4, pix_a, e);
    cmp_q("two_frames", obs_a, e);
    if (obs_a.size() > 4)
      check_eq("frame2_first", obs_a[4], mkw(1'b0, 72'h64_65_66_68_69_6A_6C_6D_6E));
    check_eq("two_frames_lasts", 73'(count_last(obs_a)), 73'(2));

    // Reset after 7 pixels, then a full frame.
    pix_a = {};
    for (int i = 0; i < 16; i++) pix_a.push_back(8'(i));
    obs_a = {};
    run_a(7, 0);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_eq("midrst_no_window", 73'(obs_a.size()), 73'(0));
    run_a(16, 0);
    cmp_q("after_rst", obs_a, exp44);

    // Random handshakes: B 5x3 one frame, C 7x5 two frames, D 3x3 three frames.
    pix_b = {}; pix_c = {}; pix_d = {};
    for (int i = 0; i < 15; i++) pix_b.push_back(8'($urandom_range(255, 0)));
    for (int i = 0; i < 70; i++) pix_c.push_back(8'($urandom_range(255, 0)));
    for (int i = 0; i < 27; i++) pix_d.push_back(8'($urandom_range(255, 0)));
    obs_b = {}; obs_c = {}; obs_d = {};
    run_rand();
    build_exp(5, 3, pix_b, e);
    cmp_q("rand53", obs_b, e);
    check_eq("rand53_count", 73'(obs_b.size()), 73'(3));
    build_exp(7, 5, pix_c, e);
    cmp_q("rand75", obs_c, e);
    check_eq("rand75_lasts", 73'(count_last(obs_c)), 73'(2));
    build_exp(3, 3, pix_d, e);
    cmp_q("rand33", obs_d, e);
    check_eq("rand33_lasts", 73'(count_last(obs_d)), 73'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
